// File: rtl/bcpu_ibus_unit_pkg.sv
// Shared BCPU16 definitions for the I/O bus unit: bus opcode encoding,
// the result record layout and the channel packing helper.
package bcpu_defs;

  typedef enum logic [1:0] {
    BUS_RD     = 2'd0,
    BUS_WR     = 2'd1,
    BUS_WAITE  = 2'd2,
    BUS_WAITNE = 2'd3
  } bus_wr_op_t;

  localparam int BCPU_DATA_WIDTH  = 16;
  localparam int BCPU_THREAD_BITS = 2;

  // Result record as seen by the writeback stage for the base 16-bit, 4-thread core.
  typedef struct packed {
    logic                        valid;
    logic [BCPU_THREAD_BITS-1:0] thread;
    logic                        we;
    logic [BCPU_DATA_WIDTH-1:0]  data;
    logic                        z;
    logic                        retry;
    logic                        timeout;
  } bus_result_t;

  function automatic int ch_ofs(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/bcpu_ibus_unit_sync.sv
// BUS_IN synchronizer: an independent flop chain per channel, or a plain
// wire-through when no stages are requested.
module bcpu_ibus_sync
  import bcpu_defs::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int STAGES     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] d,
  output logic [CHANNELS*DATA_WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] stg [STAGES];

        always_ff @(posedge clk) begin
          if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
              stg[i] <= '0;
            end
          end else begin
            stg[0] <= d[ch_ofs(k, DATA_WIDTH) +: DATA_WIDTH];
            for (int i = 1; i < STAGES; i++) begin
              stg[i] <= stg[i-1];
            end
          end
        end

        assign q[ch_ofs(k, DATA_WIDTH) +: DATA_WIDTH] = stg[STAGES-1];
      end
    end
  endgenerate

endmodule

// File: rtl/bcpu_ibus_unit.sv
// BCPU16 I/O bus execution unit: IN/OUT/WAITE/WAITNE for all barrel threads,
// with output port registers and per-thread wait-retry timeout accounting.
module bcpu_ibus_unit
  import bcpu_defs::*;
#(
  parameter int                            DATA_WIDTH      = 16,
  parameter int                            ADDR_WIDTH      = 3,
  parameter int                            THREAD_BITS     = 2,
  parameter int                            TIMEOUT_WIDTH   = 8,
  parameter int                            SYNC_STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0]         OUT_RESET_VALUE = '0
) (
  input  logic                                       CLK,
  input  logic                                       RESET,
  input  logic                                       OP_VALID,
  input  logic [THREAD_BITS-1:0]                     OP_THREAD,
  input  logic [1:0]                                 OP_CODE,
  input  logic [ADDR_WIDTH-1:0]                      OP_ADDR,
  input  logic [DATA_WIDTH-1:0]                      OP_VALUE,
  input  logic [DATA_WIDTH-1:0]                      OP_MASK,
  input  logic [TIMEOUT_WIDTH-1:0]                   TIMEOUT,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]      BUS_IN,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]      BUS_OUT,
  output logic                                       RES_VALID,
  output logic [THREAD_BITS-1:0]                     RES_THREAD,
  output logic                                       RES_WE,
  output logic [DATA_WIDTH-1:0]                      RES_DATA,
  output logic                                       RES_ZFLAG,
  output logic                                       RES_RETRY,
  output logic                                       RES_TIMEOUT
);

  localparam int CHANNELS = 2**ADDR_WIDTH;
  localparam int THREADS  = 2**THREAD_BITS;

  logic [CHANNELS*DATA_WIDTH-1:0] in_s;
  logic [DATA_WIDTH-1:0]          in_ch [CHANNELS];
  logic [DATA_WIDTH-1:0]          out_q [CHANNELS];
  logic [TIMEOUT_WIDTH-1:0]       cnt_q [THREADS];

  bcpu_ibus_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS),
    .STAGES     (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (BUS_IN),
    .q     (in_s)
  );

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_port
      assign in_ch[k] = in_s[ch_ofs(k, DATA_WIDTH) +: DATA_WIDTH];
      assign BUS_OUT[ch_ofs(k, DATA_WIDTH) +: DATA_WIDTH] = out_q[k];
    end
  endgenerate

  bus_wr_op_t               op;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     cmp_eq;
  logic                     is_rd;
  logic                     is_wr;
  logic                     is_wait;
  logic                     cond_met;
  logic [TIMEOUT_WIDTH-1:0] cnt_cur;
  logic [TIMEOUT_WIDTH-1:0] tmo_last;
  logic                     tmo_hit;
  logic                     wait_fail;
  logic                     give_retry;
  logic                     give_timeout;
  logic [TIMEOUT_WIDTH-1:0] cnt_nxt;
  logic [DATA_WIDTH-1:0]    wr_data;

  assign op = bus_wr_op_t'(OP_CODE);

  always_comb begin
    is_rd    = (op == BUS_RD);
    is_wr    = (op == BUS_WR);
    is_wait  = (op == BUS_WAITE) || (op == BUS_WAITNE);
    rd_data  = in_ch[OP_ADDR] & OP_MASK;
    cmp_eq   = (rd_data == (OP_VALUE & OP_MASK));
    cond_met = (op == BUS_WAITE) ? cmp_eq : !cmp_eq;
    wr_data  = (out_q[OP_ADDR] & ~OP_MASK) | (OP_VALUE & OP_MASK);
  end

  // ">=" rather than "==" so that lowering TIMEOUT under a live count still fires.
  always_comb begin
    cnt_cur      = cnt_q[OP_THREAD];
    tmo_last     = TIMEOUT - TIMEOUT_WIDTH'(1);
    tmo_hit      = (TIMEOUT != '0) && (cnt_cur >= tmo_last);
    wait_fail    = OP_VALID && is_wait && !cond_met;
    give_timeout = wait_fail && tmo_hit;
    give_retry   = wait_fail && !tmo_hit;
    cnt_nxt      = '0;
    if (give_retry) begin
      cnt_nxt = (&cnt_cur) ? cnt_cur : cnt_cur + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        out_q[i] <= OUT_RESET_VALUE;
      end
      for (int i = 0; i < THREADS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (OP_VALID) begin
      cnt_q[OP_THREAD] <= cnt_nxt;
      if (is_wr) begin
        out_q[OP_ADDR] <= wr_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RES_VALID   <= 1'b0;
      RES_THREAD  <= '0;
      RES_WE      <= 1'b0;
      RES_DATA    <= '0;
      RES_ZFLAG   <= 1'b0;
      RES_RETRY   <= 1'b0;
      RES_TIMEOUT <= 1'b0;
    end else begin
      RES_VALID   <= OP_VALID;
      RES_THREAD  <= OP_VALID ? OP_THREAD : '0;
      RES_WE      <= OP_VALID && is_rd;
      RES_DATA    <= (OP_VALID && is_rd) ? rd_data : '0;
      RES_ZFLAG   <= OP_VALID && is_rd && (rd_data == '0);
      RES_RETRY   <= give_retry;
      RES_TIMEOUT <= give_timeout;
    end
  end

endmodule

// File: tb/tb_bcpu_ibus_unit.sv
// Self-checking bench for bcpu_ibus_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_bcpu_ibus_unit;
  import bcpu_defs::*;

  localparam int          DW  = 16;
  localparam int          AW  = 3;
  localparam int          TB  = 2;
  localparam int          TW  = 8;
  localparam int          SS  = 2;
  localparam int          CH  = 8;
  localparam int          TH  = 4;
  localparam logic [15:0] ORV = 16'hA5A5;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            OP_VALID;
  logic [TB-1:0]   OP_THREAD;
  logic [1:0]      OP_CODE;
  logic [AW-1:0]   OP_ADDR;
  logic [DW-1:0]   OP_VALUE;
  logic [DW-1:0]   OP_MASK;
  logic [TW-1:0]   TIMEOUT;
  logic [CH*DW-1:0] BUS_IN;
  logic [CH*DW-1:0] BUS_OUT;
  logic            RES_VALID;
  logic [TB-1:0]   RES_THREAD;
  logic            RES_WE;
  logic [DW-1:0]   RES_DATA;
  logic            RES_ZFLAG;
  logic            RES_RETRY;
  logic            RES_TIMEOUT;

  bcpu_ibus_unit #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .THREAD_BITS     (TB),
    .TIMEOUT_WIDTH   (TW),
    .SYNC_STAGES     (SS),
    .OUT_RESET_VALUE (ORV)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .OP_VALID    (OP_VALID),
    .OP_THREAD   (OP_THREAD),
    .OP_CODE     (OP_CODE),
    .OP_ADDR     (OP_ADDR),
    .OP_VALUE    (OP_VALUE),
    .OP_MASK     (OP_MASK),
    .TIMEOUT     (TIMEOUT),
    .BUS_IN      (BUS_IN),
    .BUS_OUT     (BUS_OUT),
    .RES_VALID   (RES_VALID),
    .RES_THREAD  (RES_THREAD),
    .RES_WE      (RES_WE),
    .RES_DATA    (RES_DATA),
    .RES_ZFLAG   (RES_ZFLAG),
    .RES_RETRY   (RES_RETRY),
    .RES_TIMEOUT (RES_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Reference state: port contents, retry counts, and BUS_IN as seen through the sync delay.
  logic [15:0]  m_out [CH];
  int           m_cnt [TH];
  logic [127:0] m_sq [$];
  logic [127:0] bus_in_v;
  logic [7:0]   tmo_v;
  int           n_vec;
  int           n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_out();
    logic [127:0] v;
    for (int k = 0; k < CH; k++) v[k*16 +: 16] = m_out[k];
    return v;
  endfunction

  task automatic step(input bit rst, input bit v, input int thr, input int code, input int addr,
                      input logic [15:0] val, input logic [15:0] msk, input string tag);
    logic [127:0] in_now, obs, exp;
    logic [15:0]  in_ch, e_data;
    bit           e_valid, e_we, e_z, e_retry, e_tmo, eq, cond;
    RESET     = rst;
    OP_VALID  = v;
    OP_THREAD = thr[1:0];
    OP_CODE   = code[1:0];
    OP_ADDR   = addr[2:0];
    OP_VALUE  = val;
    OP_MASK   = msk;
    BUS_IN    = bus_in_v;
    TIMEOUT   = tmo_v;
    e_valid = 0; e_we = 0; e_z = 0; e_retry = 0; e_tmo = 0; e_data = '0;
    if (rst) begin
      for (int k = 0; k < CH; k++) m_out[k] = ORV;
      for (int t = 0; t < TH; t++) m_cnt[t] = 0;
      m_sq.delete();
      for (int s = 0; s < SS; s++) m_sq.push_back('0);
    end else begin
      in_now = m_sq[0];
      in_ch  = in_now[addr*16 +: 16];
      if (v) begin
        e_valid = 1;
        case (code)
          0: begin
            e_we = 1; e_data = in_ch & msk; e_z = (e_data == 0); m_cnt[thr] = 0;
          end
          1: begin
            m_out[addr] = (m_out[addr] & ~msk) | (val & msk); m_cnt[thr] = 0;
          end
          default: begin
            eq   = ((in_ch & msk) == (val & msk));
            cond = (code == 2) ? eq : !eq;
            if (cond) m_cnt[thr] = 0;
            else if (tmo_v != 0 && m_cnt[thr] >= int'(tmo_v) - 1) begin
              e_tmo = 1; m_cnt[thr] = 0;
            end else begin
              e_retry = 1;
              if (m_cnt[thr] < 255) m_cnt[thr] = m_cnt[thr] + 1;
            end
          end
        endcase
      end
      void'(m_sq.pop_front());
      m_sq.push_back(bus_in_v);
    end
    @(posedge CLK);
    #1;
    if (rst)
      obs = {105'h0, RES_VALID, RES_THREAD, RES_WE, RES_DATA, RES_ZFLAG, RES_RETRY, RES_TIMEOUT};
    else
      obs = {105'h0, RES_VALID, (e_valid ? RES_THREAD : 2'b00), RES_WE, (e_we ? RES_DATA : 16'h0),
             (e_we ? RES_ZFLAG : 1'b0), RES_RETRY, RES_TIMEOUT};
    exp = {105'h0, e_valid, (e_valid ? thr[1:0] : 2'b00), e_we, e_data, e_z, e_retry, e_tmo};
    chk($sformatf("%s_res", tag), obs, exp);
    chk($sformatf("%s_out", tag), BUS_OUT, pack_out());
  endtask

  logic [15:0] masks [4] = '{16'hFFFF, 16'h0003, 16'h0001, 16'h0F0F};

  initial begin
    int r, ci;
    logic [15:0] rm;
    n_vec = 0; n_err = 0;
    bus_in_v = '0; tmo_v = '0;

    // Reset with a write presented: it must be dropped.
    step(1, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF, "rst0");
    step(1, 0, 0, 0, 0, 16'h0, 16'h0, "rst1");
    chk("rst_bus_out", BUS_OUT, {8{16'hA5A5}});

    step(0, 1, 1, 1, 3, 16'hFFFF, 16'h00F0, "wr3");
    chk("wr3_ch3", {112'h0, BUS_OUT[48 +: 16]}, {112'h0, 16'hA5F5});

    bus_in_v[32 +: 16] = 16'h1234;
    step(0, 0, 0, 0, 0, 16'h0, 16'h0, "idle_a");
    step(0, 0, 0, 0, 0, 16'h0, 16'h0, "idle_b");
    step(0, 1, 2, 0, 2, 16'h0, 16'h0F0F, "rd2");
    chk("rd2_data", {112'h0, RES_DATA}, {112'h0, 16'h0204});
    step(0, 1, 2, 0, 2, 16'h0, 16'h0000, "rd2_m0");
    chk("rd2_m0_z", {127'h0, RES_ZFLAG}, 128'h1);

    // Sync latency: input change at M satisfies only the op issued at M+2.
    bus_in_v[16 +: 16] = 16'h0001;
    step(0, 1, 0, 2, 1, 16'h1, 16'h1, "sync_m0");
    chk("sync_m0_retry", {127'h0, RES_RETRY}, 128'h1);
    step(0, 1, 0, 2, 1, 16'h1, 16'h1, "sync_m1");
    step(0, 1, 0, 2, 1, 16'h1, 16'h1, "sync_m2");
    chk("sync_m2_done", {126'h0, RES_RETRY, RES_TIMEOUT}, 128'h0);

    // Timeout of 3 on thread 2, with thread 1 traffic interleaved.
    tmo_v = 8'd3;
    step(0, 1, 2, 3, 1, 16'h1, 16'h1, "to_a");
    step(0, 1, 1, 0, 1, 16'h0, 16'hFFFF, "to_t1rd");
    step(0, 1, 1, 2, 1, 16'h0, 16'h1, "to_t1w");
    step(0, 1, 2, 3, 1, 16'h1, 16'h1, "to_b");
    step(0, 1, 1, 1, 5, 16'h5A5A, 16'hFF00, "to_t1wr");
    step(0, 1, 2, 3, 1, 16'h1, 16'h1, "to_c");
    chk("to_c_timeout", {127'h0, RES_TIMEOUT}, 128'h1);
    step(0, 1, 2, 3, 1, 16'h1, 16'h1, "to_d");
    chk("to_d_retry", {127'h0, RES_RETRY}, 128'h1);

    // No timeout: 300 failures, then the saturated count must trip TIMEOUT=255.
    tmo_v = 8'd0;
    for (int i = 0; i < 300; i++) step(0, 1, 3, 2, 0, 16'h1, 16'h1, "sat");
    tmo_v = 8'd255;
    step(0, 1, 3, 2, 0, 16'h1, 16'h1, "sat_hit");
    chk("sat_hit_timeout", {127'h0, RES_TIMEOUT}, 128'h1);

    // Reset mid-wait forgets the partial count.
    tmo_v = 8'd3;
    step(0, 1, 0, 2, 0, 16'h1, 16'h1, "rw_a");
    step(0, 1, 0, 2, 0, 16'h1, 16'h1, "rw_b");
    step(1, 1, 0, 2, 0, 16'h1, 16'h1, "rw_rst");
    step(0, 1, 0, 2, 0, 16'h1, 16'h1, "rw_c");
    chk("rw_c_retry", {127'h0, RES_RETRY}, 128'h1);
    step(0, 1, 0, 2, 0, 16'h1, 16'h1, "rw_d");
    chk("rw_d_retry", {127'h0, RES_RETRY}, 128'h1);
    step(0, 1, 0, 2, 0, 16'h1, 16'h1, "rw_e");

    // Randomized traffic with small values so waits succeed and fail often.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) begin
        ci = $urandom_range(0, 7);
        bus_in_v[ci*16 +: 16] = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) tmo_v = 8'($urandom_range(0, 5));
      rm = ($urandom_range(0, 4) == 0) ? 16'($urandom) : masks[$urandom_range(0, 3)];
      if (r < 2)
        step(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
             16'($urandom), rm, "rnd_rst");
      else
        step(0, r >= 12, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
             16'($urandom_range(0, 3)), rm, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcpu_ibus_unit.md
# bcpu_ibus_unit

Parametrised BCPU16 I/O bus execution unit for the 0_0011 instruction group (IN, OUT, WAITE, WAITNE). It sits beside the ALU in the barrel pipeline and accepts one bus operation per cycle from any hardware thread. It owns the output port registers and an optional input synchronizer. It adds per-thread wait-retry accounting with a programmable timeout, which the single-thread 16-bit bus has never had.

## Interface
Clock `CLK`; reset `RESET`, synchronous, active-high; one clock domain.

Parameters:
- DATA_WIDTH, 16, bus port and register width
- ADDR_WIDTH, 3, port index width; CHANNELS = 2**ADDR_WIDTH
- THREAD_BITS, 2, thread id width; THREADS = 2**THREAD_BITS
- TIMEOUT_WIDTH, 8, width of the wait-retry counters
- SYNC_STAGES, 2, BUS_IN flop stages (0..3; 0 = direct)
- OUT_RESET_VALUE, 0, reset value of every BUS_OUT channel

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- OP_VALID  in  1  bus op issued this cycle
- OP_THREAD  in  THREAD_BITS  issuing thread
- OP_CODE  in  2  bus_wr_op_t
- OP_ADDR  in  ADDR_WIDTH  channel index (i3 generalised)
- OP_VALUE  in  DATA_WIDTH  Ra: compare/write value
- OP_MASK  in  DATA_WIDTH  Rb: bit mask
- TIMEOUT  in  TIMEOUT_WIDTH  max failed wait attempts; 0 = wait forever
- BUS_IN  in  CHANNELS*DATA_WIDTH  input ports, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- BUS_OUT  out  CHANNELS*DATA_WIDTH  output port registers, same packing
- RES_VALID  out  1  result for the op issued the previous cycle
- RES_THREAD  out  THREAD_BITS  thread of that result
- RES_WE  out  1  write RES_DATA to Rd (IN only)
- RES_DATA  out  DATA_WIDTH  IN result
- RES_ZFLAG  out  1  Z flag for IN, valid when RES_WE=1
- RES_RETRY  out  1  wait not satisfied; thread re-executes the same instruction
- RES_TIMEOUT  out  1  wait abandoned; thread proceeds

## Operation
- Let `in_s[k]` be BUS_IN channel k after SYNC_STAGES flops. Let `ch` be OP_ADDR and `t` be OP_THREAD.
- READ: RES_DATA = in_s[ch] & OP_MASK. RES_WE=1. RES_ZFLAG = (RES_DATA==0).
- WRITE: BUS_OUT[ch] <= (BUS_OUT[ch] & ~OP_MASK) | (OP_VALUE & OP_MASK). Other channels hold. RES_WE=0.
- WAITE: the condition is (in_s[ch] & OP_MASK) == (OP_VALUE & OP_MASK).
- WAITNE: the condition is the negation of the WAITE condition.
- Each thread has a retry counter cnt[t] of TIMEOUT_WIDTH bits.
- Wait, condition true: complete (RES_RETRY=0, RES_TIMEOUT=0). cnt[t] <= 0.
- Wait, condition false, TIMEOUT!=0 and cnt[t]==TIMEOUT-1: RES_TIMEOUT=1, RES_RETRY=0, cnt[t] <= 0.
- Wait, condition false, otherwise: RES_RETRY=1, cnt[t] <= cnt[t]+1.
- With TIMEOUT=0 the counter saturates at all-ones and never times out.
- Any READ or WRITE from thread t clears cnt[t]. Ops from other threads never touch cnt[t].
- With OP_VALID=0, all RES_* flags are 0 the next cycle, and BUS_OUT and the counters hold.
- Loopback is external: IN never reads BUS_OUT.

## Timing
- Issue at cycle N produces RES_* at cycle N+1, all registered. BUS_OUT reflects a WRITE at N+1.
- One op per cycle, back-to-back from any threads, no stalls. The unit is always ready.
- BUS_IN latency to the compare point is SYNC_STAGES cycles. A change at cycle M is visible to ops issued at M+SYNC_STAGES.
- Same-thread re-issue may follow a retry immediately. The counter update is committed before the next cycle's compare.
- On RESET:
  - BUS_OUT = OUT_RESET_VALUE on every channel.
  - RES_VALID, RES_WE, RES_RETRY, RES_TIMEOUT, RES_ZFLAG = 0; RES_DATA = 0; RES_THREAD = 0.
  - All cnt = 0 and sync flops = 0.
  - An op presented with RESET is dropped. A wait in progress is forgotten.
- TIMEOUT is sampled each cycle. Lowering it below a live cnt[t] makes the next failed attempt (cnt[t] >= TIMEOUT-1) time out.

## Structure
- bus_wr_op_t stays in bcpu_defs.
- Add CH_OFS(k) packing helper and a bus_result_t struct {valid, thread, we, data, z, retry, timeout} to bcpu_defs.
- Sub-module bcpu_ibus_sync: per-channel SYNC_STAGES flop chain with generate bypass for 0.
- Core: retry-counter array, compare/mask datapath, output register bank.

## Test plan
- Reset with OUT_RESET_VALUE=16'hA5A5 -> every BUS_OUT channel = A5A5 and all RES_* = 0 on the first post-reset cycle.
- WRITE ch3, value FFFF, mask 00F0, over A5A5 -> BUS_OUT ch3 = A5F5 at N+1, other channels unchanged. Then READ ch2 with BUS_IN ch2 = 1234, mask 0F0F -> RES_DATA=0204, RES_WE=1, Z=0. With mask 0000 -> RES_DATA=0, Z=1.
- SYNC_STAGES=2: BUS_IN ch1 goes 0000->0001 at cycle M, WAITE value 1 mask 1 issued every cycle -> RES_RETRY on ops issued at M and M+1; completion for the op issued at M+2.
- TIMEOUT=3, thread 2 WAITNE on a constant-equal input -> results RETRY, RETRY, TIMEOUT, then cnt[2]=0. Interleaved thread 1 ops leave cnt[2] unaffected.
- TIMEOUT=0, 300 failed waits -> RES_RETRY every time, never RES_TIMEOUT, counter saturates at FF.
- RESET asserted mid-wait with cnt[0]=2 and TIMEOUT=3 -> after reset, two more failed waits from thread 0 return RETRY, not TIMEOUT.
